// File: rtl/prog_mem_loader.sv
// prog_mem_loader: 16x8 CPU program memory with a valid/ready byte-stream boot loader.
//   Holds the CPU in reset (cpu_clr) while LOAD_WORDS bytes are streamed into the array,
//   then releases it and serves the CPU bus (read/write/address/memoryIn/memoryOut).
//   Optional feature macro: LOADER_CHECKSUM_EN adds a trailing checksum byte (CHECK/ERROR).
// Ports:
//   clk        in   system clock, rising edge
//   clr        in   asynchronous active-low reset
//   start      in   begin a load session (honoured in IDLE, RUN, ERROR)
//   ld_valid   in   load byte present
//   ld_data    in   load byte
//   ld_ready   out  loader accepts a byte (LOAD, CHECK)
//   cpu_clr    out  CPU reset, active-high, low only in RUN
//   done       out  image loaded, CPU running (RUN)
//   err        out  checksum failure (ERROR)
//   read       in   CPU read strobe (reads are combinational, so unused)
//   write      in   CPU write strobe (honoured in RUN only)
//   address    in   CPU address
//   memoryIn   in   CPU write data
//   memoryOut  out  mem[address], combinational
module prog_mem_loader #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int LOAD_WORDS = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              cpu_clr,
    output logic              done,
    output logic              err,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] memoryIn,
    output logic [DATA_W-1:0] memoryOut
);
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, ERROR} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] wptr;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              hs, ld_we, cpu_we, last, restart;
    logic              unused_read;

    assign unused_read = read;
    assign hs          = ld_valid && ld_ready;
    assign ld_we       = hs && state == LOAD;
    assign cpu_we      = write && state == RUN;
    assign last        = wptr == ADDR_W'(LOAD_WORDS - 1);
    assign restart     = start && (state == IDLE || state == RUN || state == ERROR);

    assign ld_ready  = state == LOAD || state == CHECK;
    assign cpu_clr   = state != RUN;
    assign done      = state == RUN;
    assign memoryOut = mem[address];

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum, chk;

    assign chk = sum + ld_data;
    assign err = state == ERROR;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            sum <= '0;
        else if (restart)
            sum <= '0;
        else if (ld_we)
            sum <= chk;
    end
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, RUN, ERROR: state_nx = start ? LOAD : state;
`ifdef LOADER_CHECKSUM_EN
            LOAD:  state_nx = (hs && last) ? CHECK : LOAD;
            CHECK: state_nx = hs ? (chk == '0 ? RUN : ERROR) : CHECK;
`else
            LOAD:  state_nx = (hs && last) ? RUN : LOAD;
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            wptr  <= '0;
        end else begin
            state <= state_nx;
            if (restart)
                wptr <= '0;
            else if (ld_we)
                wptr <= wptr + 1'b1;
        end
    end

    // Loader and CPU writes are state-exclusive; array contents are never reset.
    always_ff @(posedge clk) begin
        if (ld_we)
            mem[wptr] <= ld_data;
        else if (cpu_we)
            mem[address] <= memoryIn;
    end
endmodule
